// File: rtl/sysbus_mem_responder.sv
// Sysbus memory target: serves one 64-byte line read or write at a time from a line-organised array.
// Reads return 8 contiguous beats starting LATENCY cycles after reqack; writes commit whole lines.
module sysbus_mem_responder #(
  parameter int LINES   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  input  logic        respack,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  output logic        busy
);

  localparam int AW = $clog2(LINES);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [3:0] TYPE_MEM = 4'b0001;

  typedef enum logic [1:0] {IDLE, WDATA, RLAT, RDATA} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   line;
  logic [12:0]     tag;
  logic [2:0]      cnt;
  logic [LW-1:0]   lat;
  logic [447:0]    wbuf;
  logic [511:0]    rbuf;
  logic [511:0]    mem [LINES];

  logic accept, capture, advance, rload, commit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // reqack high blocks a new accept so every ack is a single-cycle pulse,
  // including the non-memory read that acks and stays in IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: if (reqcyc && !reqack) begin
        accept = 1'b1;
        if (!reqtag[12])                  state_nxt = WDATA;
        else if (reqtag[11:8] == TYPE_MEM) state_nxt = RLAT;
      end
      WDATA: if (reqcyc && !reqack) begin
        capture = 1'b1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      RLAT: if (lat == '0) state_nxt = RDATA;
      RDATA: if (respack) begin
        advance = 1'b1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
    end
  end

  assign rload  = (state == RLAT) && (lat == '0) && !reset;
  assign commit = capture && (cnt == 3'd7) && (tag[11:8] == TYPE_MEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      reqack  <= 1'b0;
      respcyc <= 1'b0;
      resp    <= '0;
      resptag <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      lat     <= '0;
      line    <= '0;
      tag     <= '0;
    end else begin
      reqack <= accept;
      busy   <= (state_nxt != IDLE);
      if (accept) begin
        line <= req[6 +: AW];
        tag  <= reqtag;
        cnt  <= '0;
        lat  <= LW'(LATENCY - 1);
      end
      if (capture) cnt <= cnt + 3'd1;
      if (state == RLAT) begin
        if (lat == '0) begin
          respcyc <= 1'b1;
          resp    <= mem[line][63:0];
          resptag <= tag;
        end else begin
          lat <= lat - LW'(1);
        end
      end
      if (advance) begin
        if (cnt == 3'd7) begin
          respcyc <= 1'b0;
          resp    <= '0;
          cnt     <= '0;
        end else begin
          cnt  <= cnt + 3'd1;
          resp <= rbuf[127:64];
        end
      end
    end
  end

  // Write beats shift in from the top so word 0 ends up in the low bits at commit.
  always_ff @(posedge clk) begin
    if (capture) wbuf <= {req, wbuf[447:64]};
    if (commit)  mem[line] <= {req, wbuf};
    if (rload)   rbuf <= mem[line];
    else if (advance) rbuf <= rbuf >> 64;
  end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Sysbus target (responder) model of main memory. It sits at the far end of the bus from the cache arbiter and serves 64-byte line reads and writes issued by the dcache/icache arbitration path.
- Backed by an internal line-organised array.
- Serves one transaction at a time.
- Provides a fixed, programmable read latency for performance and corner-case testing.

Parameters:
- LINES, 1024, number of 64-byte lines in the backing array (power of two).
- LATENCY, 4, cycles from the reqack cycle to the first read beat (minimum 1).

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- reqcyc  in  1  request cycle valid
- req  in  64  address beat, then write data beats
- reqtag  in  13  {wr[12], type[11:8], priv[7:0]}; wr READ=1, WRITE=0; type MEMORY=4'b0001
- reqack  out  1  one-cycle request acknowledge
- respcyc  out  1  response beat valid
- respack  in  1  response beat accepted
- resp  out  64  response data beat
- resptag  out  13  tag of the request being answered
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Synchronous, active-high. State goes to IDLE.
  - reqack, respcyc and busy reset to 0; resp and resptag reset to 0.
  - Beat counter and latency counter cleared.
  - Array contents are NOT reset.
  - Reset mid-transaction aborts it; a partially received write is discarded.
- Addressing:
  - Line index = req[6 +: log2(LINES)]. Higher address bits are ignored, so addresses wrap modulo LINES*64.
  - req[5:0] is ignored; all transfers are line-aligned.
- Data layout: beat n (0..7) corresponds to 64-bit word n of the line. Data is stored and returned unmodified, with no byte swapping.
- States: IDLE, WDATA, RLAT, RDATA. All outputs are registered.
- IDLE:
  - On an edge with reqcyc=1: latch req as the address and reqtag as the tag, drive reqack=1 for exactly the next cycle, and clear the beat counter.
  - If tag.wr=WRITE, go to WDATA; otherwise load the latency counter with LATENCY-1 and go to RLAT.
  - The same tag is later driven on resptag.
- WDATA:
  - Capture req as beat[cnt] on every cycle with reqcyc=1 and reqack=0. The reqack cycle itself still carries the address and must not be captured.
  - Cycles with reqcyc=0 are stalls: no capture, no timeout.
  - After the 8th beat, commit the whole line to the array on that edge and return to IDLE.
  - No response is issued for writes.
  - If tag.type != MEMORY, the beats are consumed and discarded.
- RLAT: the counter decrements each cycle. At 0, read the array line into the output buffer, drive respcyc=1 with resp=word0 and resptag=the latched tag, and go to RDATA.
- RDATA:
  - On an edge with respcyc&respack, advance to the next word.
  - respcyc stays continuously high across all 8 beats while they are being accepted. The initiator treats a respcyc drop as end of line, so there are no gaps.
  - With respack=0, hold resp/resptag and the counter.
  - When the 8th beat is accepted, respcyc<=0, resp<=0, return to IDLE.
  - If tag.type != MEMORY on a read: ack, skip RLAT/RDATA, return to IDLE with no response.
- Read-after-write: a read acknowledged after a write has committed returns the new data.
- Back-to-back requests: the earliest new reqack is the cycle after the one in which state becomes IDLE (minimum 1 idle cycle between transactions).
- reqcyc while not IDLE and not in WDATA is ignored and is not acked.
- Latency:
  - Read: first respcyc appears LATENCY cycles after the reqack cycle.
  - Total read with respack always high: 1 (ack) + LATENCY + 8 beats.

Test Plan:
- Preload line 5 with words 0x50..0x57; read addr 0x140 tag {READ,MEMORY,0x02} with LATENCY=4 -> reqack pulses once; respcyc rises 4 cycles after reqack; 8 contiguous beats 0x50..0x57; resptag=0x1102; then respcyc=0.
- Write addr 0x1C0 with beats 0xA0..0xA7 delivered the cycle after reqack, then read addr 0x1C0 -> read returns 0xA0..0xA7; no response beat during the write.
- Read with respack held low for 3 cycles at beat 2 -> resp stays at word 2 and respcyc stays high; beats 3..7 follow; still exactly 8 beats.
- Write with reqcyc dropped for 2 cycles after beat 3 -> stall, no spurious capture; the line holds exactly the 8 supplied words.
- Read addr LINES*64+0x40 -> returns the line 1 contents (wrap).
- Assert reset during RDATA beat 4 -> next cycle respcyc=0, reqack=0, busy=0; a subsequent read returns the full 8 beats correctly. Separately, a tag with type=0x2 read -> reqack pulses, no respcyc, IDLE.
